ex_stage: RTL

- Execute stage of the 5-stage RISC-V pipeline. Sits directly downstream of the ID/EX register and consumes its outputs.
- Contains the forwarding muxes, the single-cycle ALU and an iterative multicycle multiplier.
- Registers its results into the EX/MEM pipeline register, which is owned by this block.
- Drives MulStall_o. Top level ORs it with MemStall into the stall inputs of PC, IF/ID and ID/EX.

---
 rtl/ex_pkg.sv | 71 +++++++
 rtl/iter_mul.sv | 76 +++++++
 rtl/ex_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp values, funct fields,
// internal ALU control codes and the multiplier FSM states.
package ex_pkg;

  // ALUOp encodings from ID/EX
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpRType = 2'b10;
  localparam logic [1:0] AluOpIType = 2'b11;

  // funct7 values
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  // funct3 values
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Sr     = 3'b101;
  localparam logic [2:0] F3And    = 3'b111;

  typedef enum logic [2:0] {
    AluZero,
    AluAdd,
    AluSub,
    AluAnd,
    AluXor,
    AluSll,
    AluSra,
    AluMul
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MulIdle,
    MulBusy,
    MulDone
  } mul_state_e;

  // Map ALUOp plus {funct7, funct3} onto an internal ALU operation
  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op, input logic [9:0] alu_fn);
    alu_ctrl_e ctrl;
    ctrl = AluZero;
    case (alu_op)
      AluOpAdd: ctrl = AluAdd;
      AluOpSub: ctrl = AluSub;
      AluOpRType: begin
        case (alu_fn)
          {F7Base, F3And}:      ctrl = AluAnd;
          {F7Base, F3Xor}:      ctrl = AluXor;
          {F7Base, F3Sll}:      ctrl = AluSll;
          {F7Base, F3AddSub}:   ctrl = AluAdd;
          {F7Alt, F3AddSub}:    ctrl = AluSub;
          {F7MulDiv, F3AddSub}: ctrl = AluMul;
          default:              ctrl = AluZero;
        endcase
      end
      AluOpIType: begin
        // I-type decodes on funct3 only; the upper immediate bits are not checked
        case (alu_fn[2:0])
          F3AddSub: ctrl = AluAdd;
          F3Sr:     ctrl = AluSra;
          default:  ctrl = AluZero;
        endcase
      end
      default: ctrl = AluZero;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// Produces the low 32 bits of the product, which is identical for signed and
// unsigned operands.
module iter_mul
  import ex_pkg::*;
#(
  parameter int unsigned MUL_BITS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start,
  input  logic        step_en,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        done,
  output logic [31:0] product
);

  localparam int unsigned Steps     = 32 / MUL_BITS;
  localparam logic [5:0]  StepsInit = 6'(Steps);

  mul_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] partial;

  // Partial product of the multiplicand and the low MUL_BITS multiplier bits
  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end
  end

  // Multiplier FSM; step_en low freezes every register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MulIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (step_en) begin
      case (state_q)
        MulIdle: begin
          if (start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
            cnt_q    <= StepsInit;
            state_q  <= MulBusy;
          end
        end
        MulBusy: begin
          acc_q    <= acc_q + partial;
          mcand_q  <= mcand_q << MUL_BITS;
          mplier_q <= mplier_q >> MUL_BITS;
          cnt_q    <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_q <= MulDone;
          end
        end
        MulDone: state_q <= MulIdle;
        default: state_q <= MulIdle;
      endcase
    end
  end

  assign done    = (state_q == MulDone);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiplier
// and the EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned MUL_BITS = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemStall_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [9:0]  ALU_i,
  input  logic [31:0] Readdata1_i,
  input  logic [31:0] Readdata2_i,
  input  logic [31:0] Imm_i,
  input  logic [4:0]  Rs1_i,
  input  logic [4:0]  Rs2_i,
  input  logic [4:0]  Rd_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_Rd_i,
  input  logic [31:0] MEMWB_Data_i,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] WriteData_o,
  output logic [4:0]  Rd_o,
  output logic        MulStall_o
);

  alu_ctrl_e   ctrl;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] mul_prod;
  logic        is_mul;
  logic        mul_done;
  logic        mul_stall;

  // Forwarding muxes; EX/MEM takes priority over MEM/WB, x0 never forwards
  always_comb begin
    fwd_a = Readdata1_i;
    if (RegWrite_o && (Rd_o != 5'd0) && (Rd_o == Rs1_i)) begin
      fwd_a = ALUResult_o;
    end else if (MEMWB_RegWrite_i && (MEMWB_Rd_i != 5'd0) && (MEMWB_Rd_i == Rs1_i)) begin
      fwd_a = MEMWB_Data_i;
    end

    fwd_b = Readdata2_i;
    if (RegWrite_o && (Rd_o != 5'd0) && (Rd_o == Rs2_i)) begin
      fwd_b = ALUResult_o;
    end else if (MEMWB_RegWrite_i && (MEMWB_Rd_i != 5'd0) && (MEMWB_Rd_i == Rs2_i)) begin
      fwd_b = MEMWB_Data_i;
    end
  end

  assign op_b   = ALUSrc_i ? Imm_i : fwd_b;
  assign ctrl   = alu_decode(ALUOp_i, ALU_i);
  assign is_mul = (ctrl == AluMul);

  // Single-cycle ALU; mul comes from the iterative unit, unknown ops give 0
  always_comb begin
    case (ctrl)
      AluAdd:  alu_res = fwd_a + op_b;
      AluSub:  alu_res = fwd_a - op_b;
      AluAnd:  alu_res = fwd_a & op_b;
      AluXor:  alu_res = fwd_a ^ op_b;
      AluSll:  alu_res = fwd_a << op_b[4:0];
      AluSra:  alu_res = $signed(fwd_a) >>> Imm_i[4:0];
      default: alu_res = '0;
    endcase
  end

  iter_mul #(
    .MUL_BITS(MUL_BITS)
  ) u_iter_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start   (is_mul),
    .step_en (!MemStall_i),
    .op_a    (fwd_a),
    .op_b    (fwd_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Gating with rst_i drops the stall immediately when a multiply is aborted
  assign mul_stall  = !rst_i && is_mul && !mul_done;
  assign MulStall_o = mul_stall;

  // EX/MEM register: hold on MemStall, load a bubble while the multiplier stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      RegWrite_o  <= 1'b0;
      MemToReg_o  <= 1'b0;
      MemRead_o   <= 1'b0;
      MemWrite_o  <= 1'b0;
      ALUResult_o <= '0;
      WriteData_o <= '0;
      Rd_o        <= '0;
    end else if (!MemStall_i) begin
      if (mul_stall) begin
        RegWrite_o  <= 1'b0;
        MemToReg_o  <= 1'b0;
        MemRead_o   <= 1'b0;
        MemWrite_o  <= 1'b0;
        ALUResult_o <= '0;
        WriteData_o <= '0;
        Rd_o        <= '0;
      end else begin
        RegWrite_o  <= RegWrite_i;
        MemToReg_o  <= MemToReg_i;
        MemRead_o   <= MemRead_i;
        MemWrite_o  <= MemWrite_i;
        ALUResult_o <= is_mul ? mul_prod : alu_res;
        WriteData_o <= fwd_b;
        Rd_o        <= Rd_i;
      end
    end
  end

endmodule
